// File: rtl/h14tx_pkg.sv
// Shared types, mode table and divider-select encoding for the HDMI TX clock manager.
package h14tx_pkg;

  // Index width of the divider table; the table holds up to MAX_MODES entries.
  localparam int unsigned MODE_IDX_W = 3;
  localparam int unsigned MAX_MODES  = 8;

  // Raw PLL divider values for one mode.
  typedef struct packed {
    logic [5:0] idiv;
    logic [6:0] mdiv;
    logic [6:0] odiv;
  } pll_cfg_t;

  // Dynamic divider selects as presented to the PLL.
  typedef struct packed {
    logic [5:0] idsel;
    logic [6:0] mdsel;
    logic [6:0] odsel;
  } pll_sel_t;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } clk_state_e;

  // Divider table; the first NumModes entries are reachable from the top level.
  localparam pll_cfg_t MODE_TABLE [MAX_MODES] = '{
    '{idiv: 6'd3, mdiv: 7'd55, odiv: 7'd4},
    '{idiv: 6'd1, mdiv: 7'd27, odiv: 7'd8},
    '{idiv: 6'd4, mdiv: 7'd37, odiv: 7'd2},
    '{idiv: 6'd2, mdiv: 7'd25, odiv: 7'd4},
    '{idiv: 6'd1, mdiv: 7'd10, odiv: 7'd16},
    '{idiv: 6'd2, mdiv: 7'd40, odiv: 7'd8},
    '{idiv: 6'd5, mdiv: 7'd62, odiv: 7'd2},
    '{idiv: 6'd1, mdiv: 7'd20, odiv: 7'd4}
  };

  // Gowin dynamic selects are the two's complement of the divider value
  // within the select field width (2^W - divider).
  function automatic pll_sel_t encode_sel(input pll_cfg_t cfg);
    pll_sel_t sel;
    sel.idsel = 6'd0 - cfg.idiv;
    sel.mdsel = 7'd0 - cfg.mdiv;
    sel.odsel = 7'd0 - cfg.odiv;
    return sel;
  endfunction

  // Encoded selects for a table entry.
  function automatic pll_sel_t mode_sel(input logic [MODE_IDX_W-1:0] idx);
    return encode_sel(MODE_TABLE[idx]);
  endfunction

endpackage

// File: rtl/h14tx_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module h14tx_sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Shift the asynchronous level through two flops to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/h14tx_clk_mgr.sv
// PLL bring-up sequencer for the HDMI TX clock: reset pulse, lock wait with
// timeout and retries, settle period, run with lock-loss recovery, and a
// mode-change handshake that reprograms the PLL dividers.
module h14tx_clk_mgr
  import h14tx_pkg::*;
#(
  parameter int unsigned NumModes     = 4,
  parameter int unsigned DefaultMode  = 0,
  parameter int unsigned ResetCycles  = 16,
  parameter int unsigned LockTimeout  = 4096,
  parameter int unsigned StableCycles = 256,
  parameter int unsigned MaxRetries   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pll_lock,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(NumModes):0]     cfg_mode,
  output logic                          cfg_err,
  output logic                          pll_rst,
  output logic [5:0]                    idsel,
  output logic [6:0]                    mdsel,
  output logic [6:0]                    odsel,
  output logic                          tmds_en,
  output logic                          locked,
  output logic                          fault,
  output logic [$clog2(NumModes)-1:0]   cur_mode,
  output logic [7:0]                    unlock_cnt
);

  localparam int unsigned MODE_W    = $clog2(NumModes);
  localparam int unsigned CFG_W     = MODE_W + 1;
  localparam int unsigned RST_CNT_W = $clog2(ResetCycles + 1);
  localparam int unsigned TO_CNT_W  = $clog2(LockTimeout + 1);
  localparam int unsigned ST_CNT_W  = $clog2(StableCycles + 1);
  localparam int unsigned RETRY_W   = $clog2(MaxRetries + 1);

  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(ResetCycles - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(LockTimeout - 1);
  localparam logic [ST_CNT_W-1:0]  ST_LAST  = ST_CNT_W'(StableCycles - 1);
  localparam pll_sel_t             DEFAULT_SEL = mode_sel(MODE_IDX_W'(DefaultMode));

  logic                 lock_s;
  clk_state_e           state_r, state_n, retry_fail_state_s;
  logic [RST_CNT_W-1:0] rst_cnt_r, rst_cnt_n;
  logic [TO_CNT_W-1:0]  to_cnt_r, to_cnt_n;
  logic [ST_CNT_W-1:0]  st_cnt_r, st_cnt_n;
  logic [RETRY_W-1:0]   retry_r, retry_n, retry_inc_s;
  logic [7:0]           unlock_cnt_r, unlock_n;
  logic [MODE_W-1:0]    cur_mode_r, mode_n;
  pll_sel_t             sel_r, sel_n;
  logic                 err_n;
  logic                 accept_s, mode_ok_s, state_change_s;
  logic                 pll_rst_r, tmds_en_r, locked_r, fault_r, cfg_ready_r, cfg_err_r;

  h14tx_sync_bit u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign accept_s           = cfg_valid && cfg_ready_r;
  assign mode_ok_s          = (cfg_mode < CFG_W'(NumModes));
  assign retry_inc_s        = retry_r + RETRY_W'(1);
  assign retry_fail_state_s = (retry_inc_s < RETRY_W'(MaxRetries)) ? RST_PLL : FAULT;
  assign state_change_s     = (state_n != state_r);

  // Next-state, counter, retry/unlock bookkeeping and mode-request handling.
  always_comb begin
    state_n   = state_r;
    rst_cnt_n = rst_cnt_r;
    to_cnt_n  = to_cnt_r;
    st_cnt_n  = st_cnt_r;
    retry_n   = retry_r;
    unlock_n  = unlock_cnt_r;
    mode_n    = cur_mode_r;
    sel_n     = sel_r;
    err_n     = 1'b0;
    case (state_r)
      RST_PLL: begin
        if (rst_cnt_r == RST_LAST) begin
          state_n = WAIT_LOCK;
        end else begin
          rst_cnt_n = rst_cnt_r + RST_CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = SETTLE;
        end else if (to_cnt_r == TO_LAST) begin
          retry_n = retry_inc_s;
          state_n = retry_fail_state_s;
        end else begin
          to_cnt_n = to_cnt_r + TO_CNT_W'(1);
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          retry_n = retry_inc_s;
          state_n = retry_fail_state_s;
        end else if (st_cnt_r == ST_LAST) begin
          retry_n = RETRY_W'(0);
          state_n = RUN;
        end else begin
          st_cnt_n = st_cnt_r + ST_CNT_W'(1);
        end
      end
      RUN: begin
        // A lock loss in RUN is a recovery, not a failed attempt: no retry count.
        if (!lock_s) begin
          state_n  = RST_PLL;
          unlock_n = (unlock_cnt_r == 8'hFF) ? unlock_cnt_r : unlock_cnt_r + 8'd1;
        end else begin
          state_n = RUN;
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = RST_PLL;
      end
    endcase
    // A valid request overrides any lock-loss transition but keeps its unlock count.
    if (accept_s && mode_ok_s) begin
      mode_n  = cfg_mode[MODE_W-1:0];
      sel_n   = mode_sel(MODE_IDX_W'(cfg_mode));
      retry_n = RETRY_W'(0);
      state_n = RST_PLL;
    end else if (accept_s) begin
      err_n = 1'b1;
    end else begin
      err_n = 1'b0;
    end
  end

  // State, counters and registered outputs; counters restart on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RST_PLL;
      rst_cnt_r    <= RST_CNT_W'(0);
      to_cnt_r     <= TO_CNT_W'(0);
      st_cnt_r     <= ST_CNT_W'(0);
      retry_r      <= RETRY_W'(0);
      unlock_cnt_r <= 8'd0;
      cur_mode_r   <= MODE_W'(DefaultMode);
      sel_r        <= DEFAULT_SEL;
      pll_rst_r    <= 1'b1;
      tmds_en_r    <= 1'b0;
      locked_r     <= 1'b0;
      fault_r      <= 1'b0;
      cfg_ready_r  <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      rst_cnt_r    <= state_change_s ? RST_CNT_W'(0) : rst_cnt_n;
      to_cnt_r     <= state_change_s ? TO_CNT_W'(0) : to_cnt_n;
      st_cnt_r     <= state_change_s ? ST_CNT_W'(0) : st_cnt_n;
      retry_r      <= retry_n;
      unlock_cnt_r <= unlock_n;
      cur_mode_r   <= mode_n;
      sel_r        <= sel_n;
      pll_rst_r    <= (state_n == RST_PLL);
      tmds_en_r    <= (state_n == RUN);
      locked_r     <= (state_n == RUN);
      fault_r      <= (state_n == FAULT);
      cfg_ready_r  <= (state_n == RUN) || (state_n == FAULT);
      cfg_err_r    <= err_n;
    end
  end

  assign cfg_ready  = cfg_ready_r;
  assign cfg_err    = cfg_err_r;
  assign pll_rst    = pll_rst_r;
  assign idsel      = sel_r.idsel;
  assign mdsel      = sel_r.mdsel;
  assign odsel      = sel_r.odsel;
  assign tmds_en    = tmds_en_r;
  assign locked     = locked_r;
  assign fault      = fault_r;
  assign cur_mode   = cur_mode_r;
  assign unlock_cnt = unlock_cnt_r;

endmodule

// File: doc/h14tx_clk_mgr.md
H14TX_CLK_MGR -- requirements
Module: h14tx_clk_mgr

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all other inputs are sampled on the rising edge of clk.
REQ-002 Parameter NumModes, default 4: number of entries in the PLL divider table.
REQ-003 Parameter DefaultMode, default 0: mode loaded at reset.
REQ-004 Parameter ResetCycles, default 16: PLL reset pulse length in cycles.
REQ-005 Parameter LockTimeout, default 4096: maximum wait for lock, in cycles.
REQ-006 Parameter StableCycles, default 256: required continuous lock before run.
REQ-007 Parameter MaxRetries, default 3: consecutive failed attempts before fault.
REQ-008 Port clk  in  1  PLL reference clock (ref_clk domain).
REQ-009 Port rst_n  in  1  asynchronous active-low reset.
REQ-010 Port pll_lock  in  1  raw PLL LOCK, asynchronous to clk.
REQ-011 Ports cfg_valid / cfg_ready  in / out  1 / 1  mode-change handshake.
REQ-012 Port cfg_mode  in  $clog2(NumModes)+1  requested mode index.
REQ-013 Port cfg_err  out  1  one-cycle pulse on an out-of-range request.
REQ-014 Port pll_rst  out  1  active-high PLL RESET.
REQ-015 Ports idsel / mdsel / odsel  out  6 / 7 / 7  PLL dynamic divider selects for the current mode.
REQ-016 Port tmds_en  out  1  release for the downstream pixel-domain reset synchroniser.
REQ-017 Ports locked / fault  out  1 / 1  state == RUN / state == FAULT.
REQ-018 Ports cur_mode / unlock_cnt  out  $clog2(NumModes) / 8  active mode / lock-loss count.

Function
REQ-019 pll_lock SHALL pass through a 2-flop synchroniser; lock_s is the synchroniser output and adds 2 cycles of latency.
REQ-020 FSM states SHALL be RST_PLL, WAIT_LOCK, SETTLE, RUN and FAULT.
REQ-021 RST_PLL SHALL hold pll_rst=1 for exactly ResetCycles cycles and then enter WAIT_LOCK.
REQ-022 In WAIT_LOCK, lock_s=1 SHALL cause a move to SETTLE; after LockTimeout cycles without lock, the retry count SHALL increment and the FSM SHALL enter RST_PLL if retry<MaxRetries, otherwise FAULT.
REQ-023 In SETTLE, lock_s=0 SHALL apply the same retry rule as a WAIT_LOCK timeout; StableCycles consecutive lock_s=1 cycles SHALL clear the retry count and move to RUN.
REQ-024 tmds_en SHALL be registered and equal 1 only in RUN; it SHALL fall the cycle after leaving RUN.
REQ-025 In RUN, lock_s=0 SHALL increment unlock_cnt (saturating at 255) and move to RST_PLL; this SHALL NOT count as a retry.
REQ-026 cfg_ready SHALL be 1 only in RUN or FAULT; a request is accepted when cfg_valid and cfg_ready are both 1.
REQ-027 An accepted request with cfg_mode<NumModes SHALL latch cur_mode, clear the retry count, enter RST_PLL, and update the divider selects in the same cycle pll_rst rises.
REQ-028 An accepted request with cfg_mode>=NumModes SHALL pulse cfg_err for one cycle and leave state, mode and outputs unchanged.
REQ-029 FAULT SHALL be left only through an accepted valid request.
REQ-030 If a lock loss and an accepted request occur in the same cycle in RUN, the request SHALL win (mode latched) and unlock_cnt SHALL still increment.
REQ-031 Each counter SHALL be $clog2(max+1) bits wide and SHALL reset on every state entry.

Reset
REQ-032 On rst_n=0: state=RST_PLL, pll_rst=1, tmds_en=0, locked=0, fault=0, cfg_ready=0, cfg_err=0, unlock_cnt=0, retry=0, cur_mode=DefaultMode, divider selects from table[DefaultMode], synchroniser flops=0.
REQ-033 A reset asserted mid-operation SHALL drop tmds_en immediately (asynchronously) and restart the full sequence on release.

Structure
REQ-034 Package h14tx_pkg SHALL hold pll_cfg_t {idiv, mdiv, odiv}, the mode divider table, the state enum, and a function that encodes divider values to the Gowin dynamic-select format.
REQ-035 The synchroniser SHALL be the sub-module h14tx_sync_bit, a 2-flop synchroniser with asynchronous active-low reset.

Verification
REQ-036 Reset release, pll_lock=1 at cycle 30 -> pll_rst high for 16 cycles, RUN/tmds_en=1 at about cycle 30+2+256, with the exact cycle checked.
REQ-037 pll_lock held 0 -> three 4096-cycle timeouts, fault=1, cfg_ready=1, pll_rst=0.
REQ-038 In RUN, pll_lock low for 1 cycle -> tmds_en falls within 3 cycles, unlock_cnt=1, resync to RUN.
REQ-039 In RUN, cfg_mode=2 -> selects become table[2], pll_rst rises the same cycle, cur_mode=2; cfg_mode=7 -> cfg_err pulse only.
REQ-040 rst_n asserted in SETTLE -> all outputs at reset values without a clock edge.
REQ-041 260 lock drops in RUN -> unlock_cnt saturates at 255.
